// File: rtl/simple_cpu_pkg.sv
// Shared opcodes, FSM state type and instruction field offsets for the multi-cycle CPU core.
package simple_cpu_pkg;

    localparam logic [2:0] OP_LDI = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_DEC = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    // Instruction layout MSB->LSB: opcode, rd, rs1, rs2, imm
    function automatic int rs2_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int rs1_lsb(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

    function automatic int rd_lsb(input int data_w, input int addr_w);
        return data_w + 2 * addr_w;
    endfunction

    function automatic int op_lsb(input int data_w, input int addr_w);
        return data_w + 3 * addr_w;
    endfunction

endpackage

// File: rtl/simple_cpu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// synchronous active-low clear of every entry.
module simple_cpu_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/simple_cpu_core.sv
// Multi-cycle CPU core (IDLE/READ/EXEC/WB); SIMPLE_CPU_CORE_SAT_EN selects saturating ADD/SUB/INC/DEC.
// Latency: 3 cycles accept->result_valid; one instruction per 4 cycles.
// Backpressure: instr_ready high only in IDLE; the source holds instr/instr_valid until accepted.
module simple_cpu_core
    import simple_cpu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int INSTR_W    = 3 + 3 * REG_ADDR_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  result,
    output logic               result_valid,
    output logic               carry_flag,
    output logic               zero_flag
);

    localparam int OP_LSB  = op_lsb(DATA_W, REG_ADDR_W);
    localparam int RD_LSB  = rd_lsb(DATA_W, REG_ADDR_W);
    localparam int RS1_LSB = rs1_lsb(DATA_W, REG_ADDR_W);
    localparam int RS2_LSB = rs2_lsb(DATA_W);
    localparam logic [DATA_W:0] ONE_EXT = {{DATA_W{1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic [INSTR_W-1:0]    instr_q;
    logic [2:0]            opcode;
    logic [REG_ADDR_W-1:0] rd, rs1, rs2;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     rs1_dat, rs2_dat, op_a, op_b;
    logic [DATA_W:0]       alu_nxt, alu_q;
    logic [DATA_W-1:0]     wb_value;
    logic                  rf_we;

    assign opcode = instr_q[OP_LSB +: 3];
    assign rd     = instr_q[RD_LSB +: REG_ADDR_W];
    assign rs1    = instr_q[RS1_LSB +: REG_ADDR_W];
    assign rs2    = instr_q[RS2_LSB +: REG_ADDR_W];
    assign imm    = instr_q[DATA_W-1:0];

    simple_cpu_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (rs1),
        .rdata_a (rs1_dat),
        .raddr_b (rs2),
        .rdata_b (rs2_dat),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (wb_value)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is masked by reset so the source never sees an accept while the core is held
    always_comb begin
        instr_ready = rst_n && (state == IDLE);
        rf_we       = (state == WB);
    end

    // Bit DATA_W carries the carry/borrow for every arithmetic op and is 0 for the rest
    always_comb begin
        alu_nxt = '0;
        case (opcode)
            OP_LDI:  alu_nxt = {1'b0, imm};
            OP_ADD:  alu_nxt = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB:  alu_nxt = {1'b0, op_a} - {1'b0, op_b};
            OP_AND:  alu_nxt = {1'b0, op_a & op_b};
            OP_OR:   alu_nxt = {1'b0, op_a | op_b};
            OP_NOT:  alu_nxt = {1'b0, ~op_a};
            OP_INC:  alu_nxt = {1'b0, op_a} + ONE_EXT;
            OP_DEC:  alu_nxt = {1'b0, op_a} - ONE_EXT;
            default: alu_nxt = '0;
        endcase
    end

    always_comb begin
        wb_value = alu_q[DATA_W-1:0];
`ifdef SIMPLE_CPU_CORE_SAT_EN
        if (alu_q[DATA_W]) begin
            case (opcode)
                OP_ADD, OP_INC: wb_value = '1;
                OP_SUB, OP_DEC: wb_value = '0;
                default:        wb_value = alu_q[DATA_W-1:0];
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q      <= '0;
            op_a         <= '0;
            op_b         <= '0;
            alu_q        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            carry_flag   <= 1'b0;
            zero_flag    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: if (instr_valid) instr_q <= instr;
                READ: begin
                    op_a <= rs1_dat;
                    op_b <= rs2_dat;
                end
                EXEC: alu_q <= alu_nxt;
                WB: begin
                    result       <= wb_value;
                    carry_flag   <= alu_q[DATA_W];
                    zero_flag    <= (wb_value == '0);
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_cpu_core.sv
// Self-checking bench for simple_cpu_core against a behavioural register-file model.
module tb_simple_cpu_core;

    localparam int IW = 20;
`ifdef SIMPLE_CPU_CORE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [7:0]    result;
    logic          result_valid;
    logic          carry_flag;
    logic          zero_flag;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] mreg [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    simple_cpu_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .result       (result),
        .result_valid (result_valid),
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag)
    );

    function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2,
                                         input logic [7:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    // Reference semantics with plain integer arithmetic
    task automatic model_exec(input logic [IW-1:0] ins, output logic [7:0] er,
                              output logic ec, output logic ez);
        int op, rd, a, b, v;
        bit c;
        op = int'(ins[19:17]);
        rd = int'(ins[16:14]);
        a  = int'(mreg[ins[13:11]]);
        b  = int'(mreg[ins[10:8]]);
        v  = 0;
        c  = 1'b0;
        case (op)
            0: v = int'(ins[7:0]);
            1: begin v = a + b; c = (v > 255); if (c) v = SAT ? 255 : v - 256; end
            2: begin v = a - b; c = (v < 0);   if (c) v = SAT ? 0 : v + 256;   end
            3: v = a & b;
            4: v = a | b;
            5: v = 255 - a;
            6: begin v = a + 1; c = (v > 255); if (c) v = SAT ? 255 : 0; end
            7: begin v = a - 1; c = (v < 0);   if (c) v = SAT ? 0 : 255; end
            default: v = 0;
        endcase
        mreg[rd] = v[7:0];
        er = v[7:0];
        ec = c;
        ez = (v == 0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    endtask

    // Drives one instruction from a negedge; returns at the negedge where result_valid is seen
    task automatic issue(input logic [IW-1:0] ins, output logic [7:0] r, output logic c,
                         output logic z, output int lat, output bit to);
        int t;
        to = 1'b0;
        lat = 0;
        r = '0; c = 1'b0; z = 1'b0;
        instr = ins;
        instr_valid = 1'b1;
        t = 0;
        while (!instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!instr_ready) begin
            to = 1'b1;
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr = IW'($urandom);
        while (!result_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!result_valid) to = 1'b1;
        r = result;
        c = carry_flag;
        z = zero_flag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({result, result_valid, carry_flag, zero_flag} !== 11'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {result, result_valid, carry_flag, zero_flag});
        end
        checks++;
        if (instr_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_low got=%b exp=0", instr_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_release got=%b exp=1", instr_ready);
        end
        model_clear();
    endtask

    task automatic test_directed();
        logic [IW-1:0] prog [12];
        logic [7:0] r, er;
        logic c, z, ec, ez;
        int lat;
        bit to;
        prog[0]  = mk(3'd0, 3'd1, 3'd0, 3'd0, 8'h23);  // LDI r1
        prog[1]  = mk(3'd0, 3'd2, 3'd0, 3'd0, 8'h14);  // LDI r2
        prog[2]  = mk(3'd1, 3'd3, 3'd1, 3'd2, 8'h00);  // ADD r3
        prog[3]  = mk(3'd2, 3'd4, 3'd2, 3'd1, 8'h00);  // SUB r4
        prog[4]  = mk(3'd0, 3'd5, 3'd0, 3'd0, 8'hFF);  // LDI r5
        prog[5]  = mk(3'd6, 3'd6, 3'd5, 3'd0, 8'h00);  // INC r6
        prog[6]  = mk(3'd7, 3'd7, 3'd0, 3'd0, 8'h00);  // DEC r7,r0
        prog[7]  = mk(3'd3, 3'd0, 3'd1, 3'd2, 8'h00);  // AND r0
        prog[8]  = mk(3'd4, 3'd5, 3'd1, 3'd2, 8'h00);  // OR r5
        prog[9]  = mk(3'd5, 3'd6, 3'd1, 3'd0, 8'h00);  // NOT r6
        prog[10] = mk(3'd1, 3'd3, 3'd3, 3'd3, 8'h00);  // ADD r3,r3,r3
        prog[11] = mk(3'd1, 3'd7, 3'd0, 3'd5, 8'h00);  // ADD r7,r0,r5
        foreach (prog[k]) begin
            model_exec(prog[k], er, ec, ez);
            issue(prog[k], r, c, z, lat, to);
            checks++;
            if (to) begin
                failures++;
                $display("FAIL dir%0d_timeout got=timeout exp=result_valid", k);
            end
            checks++;
            if (lat != 3) begin
                failures++;
                $display("FAIL dir%0d_latency got=%0d exp=3", k, lat);
            end
            checks++;
            if (r !== er) begin
                failures++;
                $display("FAIL dir%0d_result got=%h exp=%h", k, r, er);
            end
            checks++;
            if (c !== ec || z !== ez) begin
                failures++;
                $display("FAIL dir%0d_flags got=c%b z%b exp=c%b z%b", k, c, z, ec, ez);
            end
            @(negedge clk);
            checks++;
            if (result_valid !== 1'b0 || result !== er) begin
                failures++;
                $display("FAIL dir%0d_pulse_hold got=v%b r%h exp=v0 r%h", k, result_valid, result, er);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] prog [3];
        logic [7:0] er;
        logic ec, ez;
        int acc [3];
        int t;
        prog[0] = mk(3'd0, 3'd2, 3'd0, 3'd0, 8'($urandom));
        prog[1] = mk(3'd1, 3'd3, 3'd2, 3'd2, 8'($urandom));
        prog[2] = mk(3'd2, 3'd4, 3'd3, 3'd1, 8'($urandom));
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr = prog[k];
            t = 0;
            while (!instr_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (instr_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b%0d_accept got=ready%b exp=ready1", k, instr_ready);
            end
            acc[k] = cyc;
            model_exec(prog[k], er, ec, ez);
            @(posedge clk);
            for (int n = 1; n <= 3; n++) begin
                @(negedge clk);
                checks++;
                if (instr_ready !== 1'b0 || result_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b%0d_busy%0d got=ready%b valid%b exp=0 0", k, n, instr_ready, result_valid);
                end
                instr = IW'($urandom);
            end
            @(negedge clk);
            checks++;
            if (result_valid !== 1'b1 || result !== er || carry_flag !== ec || zero_flag !== ez) begin
                failures++;
                $display("FAIL b2b%0d_result got=v%b r%h c%b z%b exp=v1 r%h c%b z%b",
                         k, result_valid, result, carry_flag, zero_flag, er, ec, ez);
            end
            if (k > 0) begin
                checks++;
                if (acc[k] - acc[k-1] != 4) begin
                    failures++;
                    $display("FAIL b2b%0d_spacing got=%0d exp=4", k, acc[k] - acc[k-1]);
                end
            end
        end
        instr_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (result_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_extra_exec got=valid%b exp=valid0", result_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r, er;
        logic c, z, ec, ez;
        int lat, t;
        bit to, seen;
        issue(mk(3'd0, 3'd1, 3'd0, 3'd0, 8'h23), r, c, z, lat, to);
        model_exec(mk(3'd0, 3'd1, 3'd0, 3'd0, 8'h23), er, ec, ez);
        issue(mk(3'd0, 3'd2, 3'd0, 3'd0, 8'h14), r, c, z, lat, to);
        model_exec(mk(3'd0, 3'd2, 3'd0, 3'd0, 8'h14), er, ec, ez);
        @(negedge clk);
        instr = mk(3'd1, 3'd3, 3'd1, 3'd2, 8'h00);
        instr_valid = 1'b1;
        t = 0;
        while (!instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= result_valid;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rstmid_no_valid got=valid1 exp=valid0");
        end
        checks++;
        if ({result, carry_flag, zero_flag, instr_ready} !== 11'h0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%h exp=0", {result, carry_flag, zero_flag, instr_ready});
        end
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        model_exec(mk(3'd1, 3'd7, 3'd3, 3'd3, 8'h00), er, ec, ez);
        issue(mk(3'd1, 3'd7, 3'd3, 3'd3, 8'h00), r, c, z, lat, to);
        checks++;
        if (to || r !== er || z !== ez || c !== ec) begin
            failures++;
            $display("FAIL rstmid_add_r7 got=r%h c%b z%b to%b exp=r%h c%b z%b", r, c, z, to, er, ec, ez);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [IW-1:0] ins;
        logic [7:0] r, er;
        logic c, z, ec, ez;
        int lat;
        bit to;
        for (int k = 0; k < 60; k++) begin
            ins = IW'($urandom);
            model_exec(ins, er, ec, ez);
            issue(ins, r, c, z, lat, to);
            checks++;
            if (to || lat != 3) begin
                failures++;
                $display("FAIL rnd%0d_timing got=lat%0d to%b exp=lat3", k, lat, to);
            end
            checks++;
            if (r !== er || c !== ec || z !== ez) begin
                failures++;
                $display("FAIL rnd%0d ins=%h got=r%h c%b z%b exp=r%h c%b z%b", k, ins, r, c, z, er, ec, ez);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
